mem_writeback: RTL and testbench

- Stage directly downstream of the EX load/store unit and its synchronous data memory (DP_mem32x64k, read data Q valid one cycle after the address).
- Captures each EX instruction into an M register, selects the memory read data or the ALU result, and registers it into a W register that drives the register-file write port.
- Also provides operand forwarding and load-use stall to decode, plus load/store performance counters and a sticky protocol-error flag.

---
 rtl/mem_writeback.sv | 151 +++++++++++++++
 tb/tb_mem_writeback.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback.sv
// Memory/writeback stage: captures EX into M, picks load data or ALU result into W,
// and provides decode-side forwarding, load-use stall, load/store counters and a sticky error.
module mem_writeback #(
    parameter int DW      = 32,
    parameter int RAW     = 5,
    parameter int ZERO_HW = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ex_valid,
    input  logic           ex_load,
    input  logic           ex_store,
    input  logic           ex_wen,
    input  logic [RAW-1:0] ex_rd_idx,
    input  logic [DW-1:0]  ex_alu,
    input  logic [DW-1:0]  mem_q,
    input  logic [RAW-1:0] id_ra_idx,
    input  logic [RAW-1:0] id_rb_idx,
    input  logic [DW-1:0]  id_ra_rf,
    input  logic [DW-1:0]  id_rb_rf,
    output logic           id_stall,
    output logic [DW-1:0]  id_ra_val,
    output logic [DW-1:0]  id_rb_val,
    output logic           wb_en,
    output logic [RAW-1:0] wb_idx,
    output logic [DW-1:0]  wb_data,
    output logic [31:0]    load_cnt,
    output logic [31:0]    store_cnt,
    output logic           err
);

    logic           w_ex_store_eff;
    logic           w_ex_idx_ok;
    logic           w_ex_wen;
    logic           w_ex_conflict;
    logic [DW-1:0]  w_m_data;

    logic           r_m_valid;
    logic           r_m_load;
    logic           r_m_store;
    logic           r_m_wen;
    logic [RAW-1:0] r_m_idx;
    logic [DW-1:0]  r_m_alu;

    logic           r_w_valid;
    logic           r_w_wen;
    logic [RAW-1:0] r_w_idx;
    logic [DW-1:0]  r_w_data;

    logic [31:0]    r_load_cnt;
    logic [31:0]    r_store_cnt;
    logic           r_err;

    // A load+store conflict is demoted to a plain load.
    assign w_ex_conflict  = ex_valid & ex_load & ex_store;
    assign w_ex_store_eff = ex_store & ~ex_load;
    assign w_ex_idx_ok    = (ZERO_HW == 0) || (ex_rd_idx != '0);
    assign w_ex_wen       = ex_wen & ~w_ex_store_eff & w_ex_idx_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_load  <= 1'b0;
            r_m_store <= 1'b0;
            r_m_wen   <= 1'b0;
            r_m_idx   <= '0;
            r_m_alu   <= '0;
        end else begin
            r_m_valid <= ex_valid;
            r_m_load  <= ex_load;
            r_m_store <= w_ex_store_eff;
            r_m_wen   <= w_ex_wen;
            r_m_idx   <= ex_rd_idx;
            r_m_alu   <= ex_alu;
        end
    end

    // mem_q is only meaningful in the cycle the load sits in M.
    assign w_m_data = r_m_load ? mem_q : r_m_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_valid <= 1'b0;
            r_w_wen   <= 1'b0;
            r_w_idx   <= '0;
            r_w_data  <= '0;
        end else begin
            r_w_valid <= r_m_valid;
            r_w_wen   <= r_m_wen;
            r_w_idx   <= r_m_idx;
            r_w_data  <= w_m_data;
        end
    end

    assign wb_en   = r_w_valid & r_w_wen;
    assign wb_idx  = r_w_idx;
    assign wb_data = r_w_data;

    logic w_ra_ok;
    logic w_rb_ok;
    logic w_m_fwd_ok;
    logic w_w_fwd_ok;
    logic w_ra_m_hit;
    logic w_rb_m_hit;
    logic w_ra_w_hit;
    logic w_rb_w_hit;

    assign w_ra_ok    = (ZERO_HW == 0) || (id_ra_idx != '0);
    assign w_rb_ok    = (ZERO_HW == 0) || (id_rb_idx != '0);
    assign w_m_fwd_ok = r_m_valid & r_m_wen & ~r_m_load;
    assign w_w_fwd_ok = r_w_valid & r_w_wen;

    assign w_ra_m_hit = w_ra_ok & w_m_fwd_ok & (r_m_idx == id_ra_idx);
    assign w_rb_m_hit = w_rb_ok & w_m_fwd_ok & (r_m_idx == id_rb_idx);
    assign w_ra_w_hit = w_ra_ok & w_w_fwd_ok & (r_w_idx == id_ra_idx);
    assign w_rb_w_hit = w_rb_ok & w_w_fwd_ok & (r_w_idx == id_rb_idx);

    always_comb begin
        id_ra_val = id_ra_rf;
        if (w_ra_m_hit)      id_ra_val = r_m_alu;
        else if (w_ra_w_hit) id_ra_val = r_w_data;
    end

    always_comb begin
        id_rb_val = id_rb_rf;
        if (w_rb_m_hit)      id_rb_val = r_m_alu;
        else if (w_rb_w_hit) id_rb_val = r_w_data;
    end

    // Load data is not ready until the load reaches W, so a dependent decode waits one cycle.
    assign id_stall = r_m_valid & r_m_load & r_m_wen &
                      ((w_ra_ok & (r_m_idx == id_ra_idx)) |
                       (w_rb_ok & (r_m_idx == id_rb_idx)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_m_valid & r_m_load)  r_load_cnt  <= r_load_cnt + 32'd1;
            if (r_m_valid & r_m_store) r_store_cnt <= r_store_cnt + 32'd1;
            if (w_ex_conflict)         r_err       <= 1'b1;
        end
    end

    assign load_cnt  = r_load_cnt;
    assign store_cnt = r_store_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_writeback.sv
// Directed self-checking bench for mem_writeback: forwarding, load-use stall,
// store/load counting, zero register, protocol error, counter wrap and async reset.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_load, ex_store, ex_wen;
    logic [4:0]  ex_rd_idx;
    logic [31:0] ex_alu, mem_q;
    logic [4:0]  id_ra_idx, id_rb_idx;
    logic [31:0] id_ra_rf, id_rb_rf;
    logic        id_stall;
    logic [31:0] id_ra_val, id_rb_val;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data, load_cnt, store_cnt;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_writeback #(.DW(32), .RAW(5), .ZERO_HW(1)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_wen(ex_wen),
        .ex_rd_idx(ex_rd_idx), .ex_alu(ex_alu), .mem_q(mem_q),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
        .id_ra_rf(id_ra_rf), .id_rb_rf(id_rb_rf),
        .id_stall(id_stall), .id_ra_val(id_ra_val), .id_rb_val(id_rb_val),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .load_cnt(load_cnt), .store_cnt(store_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid  = 1'b0;
        ex_load   = 1'b0;
        ex_store  = 1'b0;
        ex_wen    = 1'b0;
        ex_rd_idx = 5'd0;
        ex_alu    = 32'h0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic wen,
                         input logic [4:0] rd, input logic [31:0] alu);
        ex_valid  = 1'b1;
        ex_load   = ld;
        ex_store  = st;
        ex_wen    = wen;
        ex_rd_idx = rd;
        ex_alu    = alu;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        mem_q     = 32'h0;
        id_ra_idx = 5'd3;  id_ra_rf = 32'hAAAA_0003;
        id_rb_idx = 5'd4;  id_rb_rf = 32'hBBBB_0004;
        step();
        step();
        #1;
        check("rst_wb_en",     {31'h0, wb_en},    32'h0);
        check("rst_wb_idx",    {27'h0, wb_idx},   32'h0);
        check("rst_wb_data",   wb_data,           32'h0);
        check("rst_stall",     {31'h0, id_stall}, 32'h0);
        check("rst_load_cnt",  load_cnt,          32'h0);
        check("rst_store_cnt", store_cnt,         32'h0);
        check("rst_err",       {31'h0, err},      32'h0);
        rst = 1'b0;
        step();

        // ALU chain with M-over-W priority
        issue(1'b0, 1'b0, 1'b1, 5'd3, 32'h11);
        step();
        issue(1'b0, 1'b0, 1'b1, 5'd3, 32'h22);
        #1;
        check("alu_fwd_m",     id_ra_val,         32'h11);
        check("alu_nostall",   {31'h0, id_stall}, 32'h0);
        step();
        idle();
        #1;
        check("alu_fwd_prio",  id_ra_val,         32'h22);
        check("alu_wb_en",     {31'h0, wb_en},    32'h1);
        check("alu_wb_idx",    {27'h0, wb_idx},   32'd3);
        check("alu_wb_data",   wb_data,           32'h11);
        check("alu_rb_rf",     id_rb_val,         32'hBBBB_0004);
        step();
        #1;
        check("alu_fwd_w",     id_ra_val,         32'h22);
        check("alu_wb_data2",  wb_data,           32'h22);
        step();
        #1;
        check("alu_wb_off",    {31'h0, wb_en},    32'h0);
        check("alu_ra_rf",     id_ra_val,         32'hAAAA_0003);

        // Load-use on operand A
        issue(1'b1, 1'b0, 1'b1, 5'd5, 32'h0);
        id_ra_idx = 5'd5; id_ra_rf = 32'hAAAA_0005;
        step();
        idle();
        mem_q = 32'hDEAD_BEEF;
        #1;
        check("ld_stall",      {31'h0, id_stall}, 32'h1);
        step();
        mem_q = 32'h0;
        #1;
        check("ld_stall_off",  {31'h0, id_stall}, 32'h0);
        check("ld_fwd_w",      id_ra_val,         32'hDEAD_BEEF);
        check("ld_wb_en",      {31'h0, wb_en},    32'h1);
        check("ld_wb_idx",     {27'h0, wb_idx},   32'd5);
        check("ld_wb_data",    wb_data,           32'hDEAD_BEEF);
        check("ld_cnt1",       load_cnt,          32'd1);
        step();

        // Store (ex_wen ignored) then load r7
        issue(1'b0, 1'b1, 1'b1, 5'd6, 32'h55);
        id_ra_idx = 5'd6; id_ra_rf = 32'hAAAA_0006;
        step();
        issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h0);
        #1;
        check("st_nostall",    {31'h0, id_stall}, 32'h0);
        check("st_nofwd",      id_ra_val,         32'hAAAA_0006);
        step();
        idle();
        mem_q = 32'h77;
        id_rb_idx = 5'd7; id_rb_rf = 32'hBBBB_0007;
        #1;
        check("st_no_wb",      {31'h0, wb_en},    32'h0);
        check("ld_stall_rb",   {31'h0, id_stall}, 32'h1);
        step();
        mem_q = 32'h0;
        #1;
        check("ld7_wb_en",     {31'h0, wb_en},    32'h1);
        check("ld7_wb_idx",    {27'h0, wb_idx},   32'd7);
        check("ld7_wb_data",   wb_data,           32'h77);
        check("ld7_fwd_rb",    id_rb_val,         32'h77);
        check("st_cnt1",       store_cnt,         32'd1);
        check("ld_cnt2",       load_cnt,          32'd2);
        id_rb_idx = 5'd4; id_rb_rf = 32'hBBBB_0004;
        step();

        // Load to r0 with decode reading r0
        issue(1'b1, 1'b0, 1'b1, 5'd0, 32'h0);
        id_ra_idx = 5'd0; id_ra_rf = 32'h1234;
        step();
        idle();
        mem_q = 32'h99;
        #1;
        check("r0_nostall",    {31'h0, id_stall}, 32'h0);
        check("r0_rf",         id_ra_val,         32'h1234);
        step();
        mem_q = 32'h0;
        #1;
        check("r0_no_wb",      {31'h0, wb_en},    32'h0);
        check("r0_rf_w",       id_ra_val,         32'h1234);
        check("r0_ld_cnt",     load_cnt,          32'd3);

        // Bubble carrying load-like fields
        ex_valid = 1'b0; ex_load = 1'b1; ex_wen = 1'b1; ex_rd_idx = 5'd9; ex_alu = 32'h5A;
        id_ra_idx = 5'd9; id_ra_rf = 32'hAAAA_0009;
        step();
        idle();
        #1;
        check("bub_nostall",   {31'h0, id_stall}, 32'h0);
        check("bub_nofwd",     id_ra_val,         32'hAAAA_0009);
        step();
        #1;
        check("bub_no_wb",     {31'h0, wb_en},    32'h0);
        check("bub_ld_cnt",    load_cnt,          32'd3);

        // Protocol error: load+store together
        issue(1'b1, 1'b1, 1'b1, 5'd8, 32'h0);
        #1;
        check("err_pre",       {31'h0, err},      32'h0);
        step();
        idle();
        mem_q = 32'h88;
        #1;
        check("err_set",       {31'h0, err},      32'h1);
        step();
        mem_q = 32'h0;
        #1;
        check("err_wb_en",     {31'h0, wb_en},    32'h1);
        check("err_wb_idx",    {27'h0, wb_idx},   32'd8);
        check("err_wb_data",   wb_data,           32'h88);
        check("err_ld_cnt",    load_cnt,          32'd4);
        check("err_st_cnt",    store_cnt,         32'd1);
        repeat (3) step();
        check("err_sticky",    {31'h0, err},      32'h1);

        // Load counter wrap
        issue(1'b1, 1'b0, 1'b1, 5'd4, 32'h0);
        #1;
        force dut.r_load_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_load_cnt;
        #1;
        check("wrap_preset",   load_cnt,          32'hFFFF_FFFF);
        step();
        idle();
        #1;
        check("wrap_hold",     load_cnt,          32'hFFFF_FFFF);
        step();
        #1;
        check("wrap_zero",     load_cnt,          32'h0);

        // Async reset with a load in M and an ALU result in W
        issue(1'b0, 1'b0, 1'b1, 5'd10, 32'hAB);
        step();
        issue(1'b1, 1'b0, 1'b1, 5'd11, 32'h0);
        step();
        idle();
        mem_q = 32'hCC;
        #1;
        check("mid_wb_pre",    {31'h0, wb_en},    32'h1);
        rst = 1'b1;
        #1;
        check("mid_wb_en",     {31'h0, wb_en},    32'h0);
        check("mid_wb_idx",    {27'h0, wb_idx},   32'h0);
        check("mid_wb_data",   wb_data,           32'h0);
        check("mid_stall",     {31'h0, id_stall}, 32'h0);
        check("mid_st_cnt",    store_cnt,         32'h0);
        check("mid_err",       {31'h0, err},      32'h0);
        step();
        rst = 1'b0;
        mem_q = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_wb",  {31'h0, wb_en}, 32'h0);
        end
        check("post_rst_ld_cnt", load_cnt,        32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
